sprite_engine: RTL
==================

SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter CORDW, default 16: signed screen/sprite coordinate width.
REQ-002 Parameter WIDTH, default 8: sprite width in source pixels.
REQ-003 Parameter HEIGHT, default 8: sprite height in source pixels.
REQ-004 Parameter SCALE, default 1: integer magnification, 1..8, both axes.
REQ-005 Parameter COLR_BITS, default 4: palette index width.
REQ-006 Parameter H_RES, default 640: visible line width for right-edge clipping.
REQ-007 Parameter TRANSP, default 0: transparent palette index.
REQ-008 Derived ADDRW = clog2(WIDTH*HEIGHT).
REQ-009 Port clk  in  1: single system clock, all logic on rising edge.
REQ-010 Port rst  in  1: asynchronous, active-high reset.
REQ-011 Port line  in  1: one-cycle pulse at the start of each line (sx at hblank start).
REQ-012 Port sx, sy  in  CORDW signed: current screen position; sx advances by 1 per cycle within a line.
REQ-013 Port sprx, spry  in  CORDW signed: sprite top-left position.
REQ-014 Port data_in  in  COLR_BITS: sprite ROM read data, valid 1 cycle after pos.
REQ-015 Port pos  out  ADDRW: sprite ROM address.
REQ-016 Port pix  out  COLR_BITS: sprite pixel index.
REQ-017 Port drawing  out  1: pix is valid for the aligned screen position.
REQ-018 Port done  out  1: one-cycle pulse when the line pass ends.

Function
REQ-019 FSM states IDLE, REG_POS, ACTIVE, WAIT_POS, SPR_LINE, DONE; IDLE->REG_POS on line.
REQ-020 REG_POS: latch sprx, spry; mid-line input changes have no effect until the next line pulse.
REQ-021 ACTIVE: sy in [spry, spry+HEIGHT*SCALE-1] -> WAIT_POS, else -> DONE.
REQ-022 WAIT_POS -> SPR_LINE when sx >= sprx-2 (ROM plus output register latency).
REQ-023 SPR_LINE -> DONE after the last column (sx-sprx = WIDTH*SCALE-1) is issued; DONE -> IDLE, done=1 for exactly that cycle.
REQ-024 Fixed latency 2: drawing=1 at cycle t+2 iff sx(t) in [max(sprx,0), min(sprx+WIDTH*SCALE-1, H_RES-1)] and sy in range.
REQ-025 Address: pos = ((sy-spry)/SCALE)*WIDTH + (sx-sprx)/SCALE; each column is repeated SCALE consecutive cycles.
REQ-026 pix at t+2 = ROM[pos(t)]; pix = 0 whenever drawing = 0.
REQ-027 Left clipping: sprx < 0 or sx already past sprx on entry -> start at column (sx-sprx)/SCALE, no earlier columns are emitted.
REQ-028 Right clipping: drawing forced 0 for sx >= H_RES; FSM still reaches DONE.
REQ-029 line pulse in any non-IDLE state aborts the pass (no done pulse) and enters REG_POS.
REQ-030 Division by SCALE uses counters, not dividers; coordinate arithmetic uses CORDW+1-bit signed values so no wrap occurs.

Reset
REQ-031 rst asserted: state=IDLE, pos=0, pix=0, drawing=0, done=0, latched positions=0, asynchronously.
REQ-032 After rst deasserts, drawing stays 0 until the first line pulse.

Configuration
REQ-033 Macro SPRITE_TRANSP_EN defined: drawing=0 and pix=0 for any source pixel equal to TRANSP; pos sequencing is unchanged.
REQ-034 SPRITE_TRANSP_EN undefined: TRANSP is ignored; every in-range pixel drives drawing=1.

Verification
REQ-035 WIDTH=8, HEIGHT=8, SCALE=2, sprx=100, spry=50, sy=50: drawing=1 for sx 100..115 (2 cycles late); pos=0,0,1,1..7,7; done pulses once.
REQ-036 Same setup: sy=65 -> pos 56..63 pairs; sy=66 -> drawing never asserted, done pulses in the cycle after ACTIVE.
REQ-037 sprx=-4, SCALE=2: drawing starts at sx=0 with pos=row base+2, ends after sx=11.
REQ-038 ROM column 3 = TRANSP=0: with SPRITE_TRANSP_EN, drawing=0 at sx 106,107; without it, drawing=1 with pix=0.
REQ-039 rst pulsed at sx=105: all outputs 0 immediately; no drawing until the next line pulse.
REQ-040 sprx=600, WIDTH=8, SCALE=8, H_RES=640: drawing ends after sx=639; done still pulses; line pulse mid-pass -> no done, new pass starts.

Source files
------------

// File: rtl/sprite_engine.sv
// sprite_engine: per-line sprite renderer with integer magnification, left/right clipping
// and a fixed two-cycle ROM/output latency. Define SPRITE_TRANSP_EN to hide TRANSP pixels.
module sprite_engine #(
  parameter int unsigned CORDW     = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HEIGHT    = 8,
  parameter int unsigned SCALE     = 1,
  parameter int unsigned COLR_BITS = 4,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned TRANSP    = 0,
  localparam int unsigned ADDRW    = $clog2(WIDTH * HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
  input  logic [COLR_BITS-1:0]    data_in,
  output logic [ADDRW-1:0]        pos,
  output logic [COLR_BITS-1:0]    pix,
  output logic                    drawing,
  output logic                    done
);

  localparam int unsigned CW = CORDW + 1;
  localparam int unsigned SW = 4;
  localparam logic signed [CW-1:0] S_ZERO  = CW'(0);
  localparam logic signed [CW-1:0] S_ONE   = CW'(1);
  localparam logic signed [CW-1:0] S_TWO   = CW'(2);
  localparam logic signed [CW-1:0] S_SCALE = CW'(SCALE);
  localparam logic signed [CW-1:0] S_SPAN  = CW'(WIDTH * SCALE);
  localparam logic signed [CW-1:0] S_TALL  = CW'(HEIGHT * SCALE);
  localparam logic signed [CW-1:0] S_HRES  = CW'(H_RES);
  localparam logic [COLR_BITS-1:0] TRANSP_IDX = COLR_BITS'(TRANSP);

`ifdef SPRITE_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REG_POS, ACTIVE, WAIT_POS, SPR_LINE, DONE} state_t;
  state_t state;

  logic signed [CORDW-1:0] sprx_r, spry_r;
  logic signed [CW-1:0]    rrem, vo;
  logic [ADDRW-1:0]        rbase, col;
  logic [SW-1:0]           sub;
  logic                    vld, vld1;

  logic signed [CW-1:0]    sx_e, sy_e, sprx_e, spry_e, dy, nx, tn;
  logic [ADDRW+SW-1:0]     st1, st2;
  logic                    opaque;

  // Sign-extended coordinates: one extra bit keeps differences from wrapping.
  assign sx_e   = {sx[CORDW-1], sx};
  assign sy_e   = {sy[CORDW-1], sy};
  assign sprx_e = {sprx_r[CORDW-1], sprx_r};
  assign spry_e = {spry_r[CORDW-1], spry_r};
  assign dy     = sy_e - spry_e;
  assign nx     = sx_e + S_ONE;
  assign tn     = nx - sprx_e;
  assign opaque = !TRANSP_EN || (data_in != TRANSP_IDX);

  // Advance the (column, sub-pixel) counter pair by one source-scaled pixel.
  function automatic logic [ADDRW+SW-1:0] step(input logic [ADDRW-1:0] c, input logic [SW-1:0] s);
    if (s == SW'(SCALE - 1)) return {c + ADDRW'(1), SW'(0)};
    return {c, s + SW'(1)};
  endfunction

  assign st1 = step(col, sub);
  assign st2 = step(st1[ADDRW+SW-1:SW], st1[SW-1:0]);

  // vo tracks the offset of the next pixel to issue; pos/vld describe the following cycle's sx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sprx_r  <= '0;
      spry_r  <= '0;
      rrem    <= '0;
      rbase   <= '0;
      vo      <= '0;
      col     <= '0;
      sub     <= '0;
      vld     <= 1'b0;
      vld1    <= 1'b0;
      pos     <= '0;
      pix     <= '0;
      drawing <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      vld     <= 1'b0;
      vld1    <= vld && !line;
      drawing <= vld1 && opaque;
      pix     <= (vld1 && opaque) ? data_in : '0;
      case (state)
        IDLE: if (line) state <= REG_POS;
        REG_POS: begin
          sprx_r <= sprx;
          spry_r <= spry;
          state  <= ACTIVE;
        end
        ACTIVE: begin
          rrem  <= dy;
          rbase <= '0;
          if (dy >= S_ZERO && dy < S_TALL) state <= WAIT_POS;
          else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        WAIT_POS: begin
          // Row base is found by repeated subtraction before the sprite is reached.
          if (rrem >= S_SCALE) begin
            rrem  <= rrem - S_SCALE;
            rbase <= rbase + ADDRW'(WIDTH);
          end else if (sx_e >= sprx_e - S_TWO) begin
            state <= SPR_LINE;
            vo    <= '0;
            col   <= '0;
            sub   <= '0;
          end
        end
        SPR_LINE: begin
          if (tn >= S_SPAN) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (tn == vo) begin
            pos        <= rbase + col;
            vld        <= (nx >= S_ZERO) && (nx < S_HRES);
            vo         <= vo + S_ONE;
            {col, sub} <= st1;
            if (vo == S_SPAN - S_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (tn > vo) begin
            // Late entry: skip two offsets per cycle until the counters catch sx.
            vo         <= vo + S_TWO;
            {col, sub} <= st2;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (line && state != IDLE) begin
        state <= REG_POS;
        done  <= 1'b0;
        vld   <= 1'b0;
      end
    end
  end

endmodule
